// File: rtl/hazard3_tick_gen_pkg.sv
// Shared constants for the machine-timer tick generator: register map and DIV field layout.
// No logic lives here beyond the INT==0 -> 1 substitution helper.
package hazard3_tick_gen_pkg;

    localparam logic [3:0] ADDR_CTRL  = 4'h0;
    localparam logic [3:0] ADDR_DIV   = 4'h4;
    localparam logic [3:0] ADDR_CTR   = 4'h8;
    localparam logic [3:0] ADDR_TICKS = 4'hC;

    localparam int DIV_INT_W    = 16;
    localparam int DIV_INT_LSB  = 8;
    localparam int DIV_FRAC_W   = 8;
    localparam int DIV_FRAC_LSB = 0;

    typedef logic [DIV_INT_W-1:0]  div_int_t;
    typedef logic [DIV_FRAC_W-1:0] div_frac_t;

    // A zero integer divisor behaves as divide-by-one.
    function automatic div_int_t int_eff(input div_int_t v);
        return (v == '0) ? div_int_t'(1) : v;
    endfunction

endpackage

// File: rtl/hazard3_frac_div.sv
// Fractional down-counter: tick and tick_nrz are registered, first tick INT_eff edges after restart.
// No backpressure; fire flags the edge on which a tick is being emitted.
module hazard3_frac_div
    import hazard3_tick_gen_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  restart,
    input  logic [DIV_INT_W-1:0]  div_int,
    input  logic [DIV_FRAC_W-1:0] div_frac,
    output logic [DIV_INT_W-1:0]  ctr,
    output logic                  fire,
    output logic                  tick,
    output logic                  tick_nrz
);

    logic [DIV_FRAC_W-1:0] frac_acc;
    logic [DIV_FRAC_W:0]   frac_sum;
    logic [DIV_INT_W-1:0]  div_int_eff;
    logic [DIV_INT_W-1:0]  reload_val;

    assign div_int_eff = int_eff(div_int);
    assign frac_sum    = {1'b0, frac_acc} + {1'b0, div_frac};
    // INT_eff-1 tops out at 65534, so adding the carry cannot wrap.
    assign reload_val  = div_int_eff - 16'd1 + {15'd0, frac_sum[DIV_FRAC_W]};
    assign fire        = en && (ctr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr      <= '0;
            frac_acc <= '0;
            tick     <= 1'b0;
            tick_nrz <= 1'b0;
        end else if (restart) begin
            ctr      <= div_int_eff - 16'd1;
            frac_acc <= '0;
            tick     <= 1'b0;
        end else if (en) begin
            if (ctr != '0) begin
                ctr  <= ctr - 16'd1;
                tick <= 1'b0;
            end else begin
                ctr      <= reload_val;
                frac_acc <= frac_sum[DIV_FRAC_W-1:0];
                tick     <= 1'b1;
                tick_nrz <= ~tick_nrz;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/hazard3_tick_gen.sv
// APB-programmable fractional tick generator for the machine timer; zero-wait APB, registered tick outputs.
// Never stalls the bus: pready tied high, pslverr tied low.
module hazard3_tick_gen
    import hazard3_tick_gen_pkg::*;
#(
    parameter logic [DIV_INT_W-1:0]  DIV_INT_RESET  = 16'd1,
    parameter logic [DIV_FRAC_W-1:0] DIV_FRAC_RESET = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        tick,
    output logic        tick_nrz
);

    logic                  en;
    logic [DIV_INT_W-1:0]  div_int;
    logic [DIV_FRAC_W-1:0] div_frac;
    logic [31:0]           ticks;
    logic [DIV_INT_W-1:0]  ctr;
    logic                  fire;

    logic addr_hit;
    logic wr;
    logic wr_ctrl;
    logic wr_div;
    logic wr_ticks;
    logic restart;
    logic unused_pwdata;

    assign pready   = 1'b1;
    assign pslverr  = 1'b0;

    assign addr_hit = (paddr[15:4] == 12'h000);
    assign wr       = psel && penable && pwrite && addr_hit;
    assign wr_ctrl  = wr && (paddr[3:0] == ADDR_CTRL);
    assign wr_div   = wr && (paddr[3:0] == ADDR_DIV);
    assign wr_ticks = wr && (paddr[3:0] == ADDR_TICKS);
    // Only a 0->1 transition of EN restarts; rewriting 1 leaves the running period alone.
    assign restart  = wr_ctrl && pwdata[0] && !en;

    assign unused_pwdata = ^pwdata[31:24];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b0;
            div_int  <= DIV_INT_RESET;
            div_frac <= DIV_FRAC_RESET;
        end else begin
            if (wr_ctrl) begin
                en <= pwdata[0];
            end
            if (wr_div) begin
                div_int  <= pwdata[DIV_INT_LSB +: DIV_INT_W];
                div_frac <= pwdata[DIV_FRAC_LSB +: DIV_FRAC_W];
            end
        end
    end

    // Software clear wins over a same-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ticks <= '0;
        end else if (wr_ticks) begin
            ticks <= '0;
        end else if (fire) begin
            ticks <= ticks + 32'd1;
        end
    end

    hazard3_frac_div u_frac_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .restart  (restart),
        .div_int  (div_int),
        .div_frac (div_frac),
        .ctr      (ctr),
        .fire     (fire),
        .tick     (tick),
        .tick_nrz (tick_nrz)
    );

    always_comb begin
        prdata = 32'h0;
        if (addr_hit) begin
            case (paddr[3:0])
                ADDR_CTRL:  prdata = {31'h0, en};
                ADDR_DIV:   prdata = {8'h00, div_int, div_frac};
                ADDR_CTR:   prdata = {16'h0000, ctr};
                ADDR_TICKS: prdata = ticks;
                default:    prdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard3_tick_gen.sv
// Bench for hazard3_tick_gen: vector table, directed corner sequences and randomized
// divider settings checked against a tick-time schedule derived from the divisor arithmetic.
module tb_hazard3_tick_gen;
    import hazard3_tick_gen_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        tick;
    logic        tick_nrz;

    int total;
    int bad;
    int cyc;

    localparam logic [15:0] A_CTRL  = {12'h000, ADDR_CTRL};
    localparam logic [15:0] A_DIV   = {12'h000, ADDR_DIV};
    localparam logic [15:0] A_CTR   = {12'h000, ADDR_CTR};
    localparam logic [15:0] A_TICKS = {12'h000, ADDR_TICKS};

    hazard3_tick_gen #(
        .DIV_INT_RESET  (16'd1),
        .DIV_FRAC_RESET (8'd0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .tick     (tick),
        .tick_nrz (tick_nrz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Returns 1 time unit after edge n (no wait if already there).
    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 unit after edge k; the write completes on edge k+2.
    task automatic apb_wr(input logic [15:0] a, input logic [31:0] d);
        paddr   = a;
        pwdata  = d;
        pwrite  = 1'b1;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_rd(input logic [15:0] a, output logic [31:0] d);
        paddr   = a;
        pwrite  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        #1;
        d       = prdata;
        psel    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Edge offset of the tick following tick n (n>=1) given the previous tick edge.
    function automatic int next_tick(input int prev, input int ie, input int fr, input int n);
        return prev + ie + ((n * fr) / 256 - ((n - 1) * fr) / 256);
    endfunction

    typedef struct {
        logic [31:0] div;
        int          cycles;
        logic [31:0] exp_ticks;
        logic [31:0] exp_ctr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] rd;
        int          e0;
        bit          any_hi;

        total   = 0;
        bad     = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        paddr   = '0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pwdata  = '0;

        vecs[0] = '{32'h0000_0400, 40, 32'd10, 32'd3};
        vecs[1] = '{32'h0000_0380, 20, 32'd6,  32'd3};
        vecs[2] = '{32'h0000_0000,  8, 32'd8,  32'd0};
        vecs[3] = '{32'h0000_0100,  8, 32'd8,  32'd0};
        vecs[4] = '{32'h0000_0540, 30, 32'd5,  32'd0};

        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apb_rd(A_CTRL, rd);  chk("rst_ctrl", rd, 32'h0);
        apb_rd(A_DIV, rd);   chk("rst_div", rd, 32'h0000_0100);
        apb_rd(A_CTR, rd);   chk("rst_ctr", rd, 32'h0);
        apb_rd(A_TICKS, rd); chk("rst_ticks", rd, 32'h0);
        chk("pready", {31'h0, pready}, 32'h1);
        chk("pslverr", {31'h0, pslverr}, 32'h0);

        any_hi = 1'b0;
        e0 = cyc;
        for (int k = 1; k <= 100; k++) begin
            wait_edge(e0 + k);
            if (tick || tick_nrz) any_hi = 1'b1;
        end
        chk("idle_outputs", {31'h0, any_hi}, 32'h0);

        // Upper address bits must block decode.
        apb_wr(16'h0010, 32'h1);
        apb_rd(A_CTRL, rd);  chk("alias_ctrl_wr", rd, 32'h0);
        apb_wr(A_DIV, 32'hFFFF_FFFF);
        apb_rd(A_DIV, rd);   chk("div_mask", rd, 32'h00FF_FFFF);
        apb_rd(16'h0104, rd); chk("alias_div_rd", rd, 32'h0);
        apb_wr(A_CTR, 32'h1234);
        apb_rd(A_CTR, rd);   chk("ctr_ro", rd, 32'h0);

        foreach (vecs[i]) begin
            apb_wr(A_DIV, vecs[i].div);
            apb_wr(A_CTRL, 32'h1);
            e0 = cyc;
            wait_edge(e0 + vecs[i].cycles);
            apb_rd(A_TICKS, rd); chk($sformatf("vec%0d_ticks", i), rd, vecs[i].exp_ticks);
            apb_rd(A_CTR, rd);   chk($sformatf("vec%0d_ctr", i), rd, vecs[i].exp_ctr);
            apb_wr(A_CTRL, 32'h0);
            apb_wr(A_TICKS, 32'h0);
        end

        // 512 periods at INT 3 / FRAC 0x80 span 512*3 + 256 cycles.
        begin
            int n;
            int t1;
            int tlast;
            do_reset();
            apb_wr(A_DIV, 32'h0000_0380);
            apb_wr(A_CTRL, 32'h1);
            e0 = cyc;
            n = 0;
            t1 = 0;
            tlast = 0;
            for (int k = 1; k <= 2000 && tlast == 0; k++) begin
                wait_edge(e0 + k);
                if (tick) begin
                    n++;
                    if (n == 1) t1 = k;
                    if (n == 513) tlast = k;
                end
            end
            chk("first_tick_int3", t1, 3);
            chk("span_512", tlast - t1, 1792);
        end

        // DIV change mid-period, then EN cleared on a reload edge.
        do_reset();
        apb_wr(A_DIV, 32'h0000_0A00);
        apb_wr(A_CTRL, 32'h1);
        e0 = cyc;
        wait_edge(e0 + 3);
        apb_wr(A_DIV, 32'h0000_0200);
        wait_edge(e0 + 9);  chk("mid_t9",  {31'h0, tick}, 32'h0);
        wait_edge(e0 + 10); chk("mid_t10", {31'h0, tick}, 32'h1);
        wait_edge(e0 + 11); chk("mid_t11", {31'h0, tick}, 32'h0);
        wait_edge(e0 + 12); chk("mid_t12", {31'h0, tick}, 32'h1);
        wait_edge(e0 + 13); chk("mid_t13", {31'h0, tick}, 32'h0);
        wait_edge(e0 + 14); chk("mid_t14", {31'h0, tick}, 32'h1);
        apb_wr(A_CTRL, 32'h0);
        chk("dis_final_tick", {31'h0, tick}, 32'h1);
        wait_edge(e0 + 17); chk("dis_t17", {31'h0, tick}, 32'h0);
        wait_edge(e0 + 20); chk("dis_t20", {31'h0, tick}, 32'h0);
        apb_rd(A_CTR, rd);   chk("dis_ctr_hold", rd, 32'h1);
        apb_rd(A_TICKS, rd); chk("dis_ticks", rd, 32'h4);

        // TICKS clear colliding with a tick, then async reset while tick is high.
        do_reset();
        apb_wr(A_DIV, 32'h0000_0400);
        apb_wr(A_CTRL, 32'h1);
        e0 = cyc;
        wait_edge(e0 + 5);
        apb_rd(A_TICKS, rd); chk("clr_pre", rd, 32'h1);
        wait_edge(e0 + 6);
        apb_wr(A_TICKS, 32'hDEAD_BEEF);
        chk("clr_tick", {31'h0, tick}, 32'h1);
        apb_rd(A_TICKS, rd); chk("clr_wins", rd, 32'h0);
        wait_edge(e0 + 12);
        apb_rd(A_TICKS, rd); chk("clr_post", rd, 32'h1);
        wait_edge(e0 + 16);
        chk("pre_rst_tick", {31'h0, tick}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_tick", {31'h0, tick}, 32'h0);
        chk("arst_nrz", {31'h0, tick_nrz}, 32'h0);
        apb_rd(A_CTR, rd);   chk("arst_ctr", rd, 32'h0);
        apb_rd(A_CTRL, rd);  chk("arst_ctrl", rd, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized divisors against the schedule model.
        for (int t = 0; t < 8; t++) begin
            int iv;
            int fr;
            int ie;
            int nt;
            int n;
            bit enrz;
            bit etick;
            iv = (t < 2) ? t : $urandom_range(0, 7);
            fr = $urandom_range(0, 255);
            ie = (iv == 0) ? 1 : iv;
            do_reset();
            apb_wr(A_DIV, (iv << 8) | fr);
            apb_wr(A_CTRL, 32'h1);
            e0 = cyc;
            nt = ie;
            n = 1;
            enrz = 1'b0;
            for (int k = 1; k <= 200; k++) begin
                wait_edge(e0 + k);
                etick = (k == nt);
                if (etick) begin
                    enrz = ~enrz;
                    nt = next_tick(nt, ie, fr, n);
                    n++;
                end
                chk($sformatf("rnd%0d_i%0d_f%0d_tick@%0d", t, iv, fr, k), {31'h0, tick}, {31'h0, etick});
                chk($sformatf("rnd%0d_i%0d_f%0d_nrz@%0d", t, iv, fr, k), {31'h0, tick_nrz}, {31'h0, enrz});
            end
            apb_rd(A_TICKS, rd);
            chk($sformatf("rnd%0d_ticks", t), rd, n - 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
